ub_vector_reader: RTL and testbench



---
 rtl/ub_pkg.sv | 9 +
 rtl/ub_skid_fifo.sv | 51 +++++
 rtl/ub_vector_reader.sv | 119 +++++++++++
 tb/tb_ub_vector_reader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ub_pkg.sv
// ub_pkg: shared constants, row type and FSM states for the unified-buffer vector reader
package ub_pkg;
  localparam int LANES  = 32;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 13;
  typedef logic [DATA_W-1:0] ub_row_t [LANES];
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
endpackage

// File: rtl/ub_skid_fifo.sv
// ub_skid_fifo: DEPTH-entry row FIFO with registered head absorbing the buffer read latency
module ub_skid_fifo
  import ub_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  ub_row_t       data_i,
  input  logic          pop_i,
  output ub_row_t       data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  ub_row_t mem_q [DEPTH];
  ub_row_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  // next pointers, count and storage; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = data_i;
    wr_d  = wr_q + AW'(push_i);
    rd_d  = rd_q + AW'(pop_i);
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  // storage and pointer registers, cleared so the head reads zero out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < LANES; j++)
          mem_q[i][j] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ub_vector_reader.sv
// ub_vector_reader: burst reader for the unified buffer streaming rows out; UB_READER_STRIDE_EN adds cmd_stride_i
module ub_vector_reader
  import ub_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
`ifdef UB_READER_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride_i,
`endif
  output logic              ub_read_o,
  output logic [ADDR_W-1:0] ub_addr_rd_o,
  input  ub_row_t           ub_data_i,
  output logic              vec_valid_o,
  input  logic              vec_ready_i,
  output ub_row_t           vec_data_o,
  output logic              vec_last_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, issued_q, issued_d, popped_q, popped_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, step;
  logic inflight_q, done_q, done_d;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic empty, full, pop, push;
`ifdef UB_READER_STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif
  assign pop          = vec_valid_o & vec_ready_i;
  assign push         = inflight_q & (!full | pop);
  assign vec_valid_o  = !empty;
  assign vec_last_o   = vec_valid_o & (popped_q + LEN_W'(1) == len_q);
  assign occ          = OW'(count) + OW'(inflight_q) - OW'(pop);
  assign ub_read_o    = (state_q == ISSUE) & (occ < OW'(FIFO_DEPTH));
  assign ub_addr_rd_o = ub_read_o ? rd_addr_q : '0;
  assign cmd_ready_o  = state_q == IDLE;
  assign busy_o       = !cmd_ready_o;
  assign done_o       = done_q;
  ub_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (ub_data_i),
    .pop_i   (pop),
    .data_o  (vec_data_o),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
  // burst sequencing: latch command in IDLE, issue reads only while the FIFO can absorb them, drain to the last row
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_addr_d = rd_addr_q;
    issued_d  = issued_q;
    popped_d  = popped_q + LEN_W'(pop);
`ifdef UB_READER_STRIDE_EN
    stride_d  = stride_q;
`endif
    done_d    = (state_q == IDLE && cmd_valid_i && cmd_len_i == '0) || (pop && vec_last_o);
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        len_d     = cmd_len_i;
        rd_addr_d = cmd_base_i;
        issued_d  = '0;
        popped_d  = '0;
`ifdef UB_READER_STRIDE_EN
        stride_d  = cmd_stride_i;
`endif
        state_d   = cmd_len_i != '0 ? ISSUE : IDLE;
      end
      ISSUE: begin
        rd_addr_d = ub_read_o ? rd_addr_q + step : rd_addr_q;
        issued_d  = issued_q + LEN_W'(ub_read_o);
        state_d   = issued_d == len_q ? DRAIN : ISSUE;
      end
      DRAIN: state_d = (pop && vec_last_o) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // control registers; inflight marks the cycle the buffer returns data for last cycle's read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rd_addr_q  <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef UB_READER_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_addr_q  <= rd_addr_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= ub_read_o;
      done_q     <= done_d;
`ifdef UB_READER_STRIDE_EN
      stride_q   <= stride_d;
`endif
    end
  end
endmodule

// File: tb/tb_ub_vector_reader.sv
// tb_ub_vector_reader: scoreboard bench with a unified-buffer memory model and random backpressure
module tb_ub_vector_reader;
  import ub_pkg::*;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [ADDR_W-1:0] cmd_stride = 12'd1;
  logic ub_read;
  logic [ADDR_W-1:0] ub_addr;
  ub_row_t ub_data;
  logic vec_valid;
  logic vec_ready = 1'b1;
  ub_row_t vec_data;
  logic vec_last, busy, done;

  ub_row_t ub_mem [4096];
  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] row_q[$];
  logic last_q[$];
  logic busy_m = 1'b0;
  logic done_exp = 1'b0;
  logic done_n;
  logic [ADDR_W-1:0] a_m, step_m;
  int reads_m = 0, pops_m = 0, cyc = 0;
  int hs_cyc = 0, first_rd = -1, first_val = -1, last_pop = -1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ub_vector_reader dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_base_i   (cmd_base),
    .cmd_len_i    (cmd_len),
`ifdef UB_READER_STRIDE_EN
    .cmd_stride_i (cmd_stride),
`endif
    .ub_read_o    (ub_read),
    .ub_addr_rd_o (ub_addr),
    .ub_data_i    (ub_data),
    .vec_valid_o  (vec_valid),
    .vec_ready_i  (vec_ready),
    .vec_data_o   (vec_data),
    .vec_last_o   (vec_last),
    .busy_o       (busy),
    .done_o       (done)
  );

  // unified buffer: registered read, output held when not reading
  always @(posedge clk) if (ub_read) ub_data <= ub_mem[ub_addr];

  function automatic logic [LANES*DATA_W-1:0] pack(input ub_row_t r);
    logic [LANES*DATA_W-1:0] p;
    for (int l = 0; l < LANES; l++) p[l*DATA_W +: DATA_W] = r[l];
    return p;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endfunction

  // monitor + scoreboard: expected addresses/rows queued at command accept, popped as the DUT presents them
  always @(negedge clk) begin
    if (!rst_ni) begin
      rd_q.delete(); row_q.delete(); last_q.delete();
      busy_m = 1'b0; done_exp = 1'b0; reads_m = 0; pops_m = 0;
    end else begin
      cyc++;
      chk("done", done, done_exp);
      chk("cmd_ready", cmd_ready, !busy_m);
      chk("busy", busy, busy_m);
      chk("occupancy_le_depth", (reads_m - pops_m) <= 2, 1);
      done_n = 1'b0;
`ifdef UB_READER_STRIDE_EN
      step_m = cmd_stride;
`else
      step_m = 12'd1;
`endif
      if (cmd_valid && !busy_m) begin
        hs_cyc = cyc; first_rd = -1; first_val = -1; last_pop = -1;
        if (cmd_len == 0) done_n = 1'b1;
        else begin
          busy_m = 1'b1;
          for (int i = 0; i < int'(cmd_len); i++) begin
            a_m = cmd_base + 12'(i) * step_m;
            rd_q.push_back(a_m);
            row_q.push_back(a_m);
            last_q.push_back(i == int'(cmd_len) - 1);
          end
        end
      end
      if (ub_read) begin
        if (first_rd < 0) first_rd = cyc;
        if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_addr", ub_addr, rd_q.pop_front());
        reads_m++;
      end
      if (vec_valid) begin
        if (first_val < 0) first_val = cyc;
        if (row_q.size() == 0) chk("unexpected_row", 1, 0);
        else begin
          n_chk++;
          if (vec_data != ub_mem[row_q[0]]) begin
            n_fail++;
            $display("FAIL row_data addr %h got %h want %h", row_q[0], pack(vec_data), pack(ub_mem[row_q[0]]));
          end
          chk("row_last", vec_last, last_q[0]);
          if (vec_ready) begin
            void'(row_q.pop_front());
            pops_m++;
            if (last_q.pop_front()) begin
              done_n = 1'b1; busy_m = 1'b0; last_pop = cyc;
            end
          end
        end
      end
      done_exp = done_n;
    end
  end

  task automatic send(input logic [11:0] b, input logic [12:0] l, input logic [11:0] s);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = b; cmd_len = l; cmd_stride = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    do begin
      @(posedge clk); #1;
      if (rnd) vec_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end while ((busy || row_q.size() != 0) && n < 500);
    chk("idle_within_budget", n < 500, 1);
    @(posedge clk); #1;
    vec_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_ub_read", ub_read, 0);
    chk("rst_ub_addr", ub_addr, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec_data_zero", pack(vec_data) == '0, 1);
    chk("rst_vec_last", vec_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    int r0;
    for (int a = 0; a < 4096; a++)
      for (int l = 0; l < LANES; l++)
        ub_mem[a][l] = 16'($urandom);
    ub_data = ub_mem[0];
    repeat (3) @(posedge clk);
    #1 chk_reset_state();
    rst_ni = 1'b1;
    send(12'h010, 13'd4, 12'd1);
    wait_idle(0);
    chk("lat_first_read", first_rd - hs_cyc, 1);
    chk("lat_first_valid", first_val - hs_cyc, 3);
    chk("lat_last_pop", last_pop - hs_cyc, 6);
    send(12'hFFE, 13'd4, 12'd1);
    wait_idle(0);
    send(12'h345, 13'd8, 12'd1);
    wait_idle(1);
    send(12'h055, 13'd0, 12'd1);
    wait_idle(0);
    r0 = reads_m;
    send(12'h200, 13'd10, 12'd1);
    for (int i = 0; i < 30 && reads_m - r0 < 3; i++) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 chk_reset_state();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    send(12'h100, 13'd2, 12'd1);
    wait_idle(0);
    for (int k = 0; k < 5; k++) begin
      send(12'($urandom_range(0, 4095)), 13'($urandom_range(1, 12)), 12'd1);
      wait_idle(1);
    end
`ifdef UB_READER_STRIDE_EN
    send(12'h000, 13'd3, 12'h020);
    wait_idle(0);
    send(12'h7F0, 13'd3, 12'h000);
    wait_idle(1);
    send(12'hFF0, 13'd4, 12'h00C);
    wait_idle(0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
